cmp_iter: RTL and testbench

CMP_ITER -- requirements
Module: cmp_iter

---
 rtl/cmp_pkg.sv | 49 ++++
 rtl/cmp_chunk.sv | 25 ++
 rtl/cmp_iter.sv | 143 ++++++++++++++
 tb/tb_cmp_iter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_pkg
//  Brief    : Shared encodings for the iterative comparator: branch
//             conditions, compare modes, FSM states and the branch evaluator.
//  Revision : 1.0  initial release
// ============================================================================
package cmp_pkg;

    // Branch condition encodings carried on BrOp (6 and 7 are reserved)
    localparam logic [2:0] BR_EQ = 3'd0;
    localparam logic [2:0] BR_NE = 3'd1;
    localparam logic [2:0] BR_LT = 3'd2;
    localparam logic [2:0] BR_LE = 3'd3;
    localparam logic [2:0] BR_GT = 3'd4;
    localparam logic [2:0] BR_GE = 3'd5;

    // Compare mode encodings carried on CMPOp
    localparam logic CMP_SIGNED   = 1'b0;
    localparam logic CMP_UNSIGNED = 1'b1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Evaluate a branch condition against a one-hot eq/lt/gt result.
    // Reserved codes never take the branch.
    function automatic logic branch_taken(input logic [2:0] br_op,
                                          input logic       eq,
                                          input logic       lt,
                                          input logic       gt);
        logic t;
        case (br_op)
            BR_EQ:   t = eq;
            BR_NE:   t = ~eq;
            BR_LT:   t = lt;
            BR_LE:   t = lt | eq;
            BR_GT:   t = gt;
            BR_GE:   t = gt | eq;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage : cmp_pkg
`default_nettype wire

// File: rtl/cmp_chunk.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_chunk
//  Brief    : Combinational unsigned compare of one CHUNK-wide slice.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Plain magnitude compare; signedness is folded in by the caller
    always_comb begin
        eq = (a == b);
        lt = (a <  b);
        gt = (a >  b);
    end

endmodule : cmp_chunk
`default_nettype wire

// File: rtl/cmp_iter.sv
`default_nettype none
// ============================================================================
//  Module   : cmp_iter
//  Brief    : Iterative magnitude comparator with branch evaluation. Walks
//             the operands one CHUNK at a time from the MSB end and stops at
//             the first differing chunk. Valid/ready on both sides.
//  Revision : 1.0  initial release
// ============================================================================
module cmp_iter
    import cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CMPOp,
    input  logic [2:0]       BrOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             less,
    output logic             greater,
    output logic             taken
);

    // Guarded divisor so a bad CHUNK reaches the check below instead of a
    // divide-by-zero during elaboration.
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Only the sign bit is flipped for signed mode: that maps two's
    // complement ordering onto unsigned ordering.
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    if ((CHUNK < 1) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_param_check
        $error("cmp_iter: WIDTH must be a non-zero multiple of CHUNK (CHUNK >= 1)");
    end

    state_e            state;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [2:0]        br_r;
    logic [WIDTH-1:0]  sign_mask;
    logic [CHUNK-1:0]  a_slice;
    logic [CHUNK-1:0]  b_slice;
    logic              c_eq;
    logic              c_lt;
    logic              c_gt;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // Mask applied to both operands at accept time to select signed ordering
    always_comb begin
        sign_mask = '0;
        case (CMPOp)
            CMP_SIGNED:   sign_mask = MSB_MASK;
            CMP_UNSIGNED: sign_mask = '0;
        endcase
    end

    // Select the chunk addressed by the current index
    always_comb begin
        a_slice = a_r[int'(idx) * CHUNK +: CHUNK];
        b_slice = b_r[int'(idx) * CHUNK +: CHUNK];
    end

    cmp_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_slice),
        .b  (b_slice),
        .eq (c_eq),
        .lt (c_lt),
        .gt (c_gt)
    );

    // Controller: accept, walk chunks MSB-first, hold result until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            br_r    <= '0;
            equal   <= 1'b0;
            less    <= 1'b0;
            greater <= 1'b0;
            taken   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= A ^ sign_mask;
                        b_r   <= B ^ sign_mask;
                        br_r  <= BrOp;
                        idx   <= IDXW'(NCHUNK - 1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!c_eq) begin
                        equal   <= 1'b0;
                        less    <= c_lt;
                        greater <= c_gt;
                        taken   <= branch_taken(br_r, 1'b0, c_lt, c_gt);
                        state   <= ST_DONE;
                    end else if (idx == '0) begin
                        equal   <= 1'b1;
                        less    <= 1'b0;
                        greater <= 1'b0;
                        taken   <= branch_taken(br_r, 1'b1, 1'b0, 1'b0);
                        state   <= ST_DONE;
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                ST_DONE: begin
                    // Returning to IDLE here means a request present on this
                    // same edge is only seen on the following one.
                    if (out_ready) begin
                        equal   <= 1'b0;
                        less    <= 1'b0;
                        greater <= 1'b0;
                        taken   <= 1'b0;
                        idx     <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : cmp_iter
`default_nettype wire

// File: tb/tb_cmp_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cmp_iter
//  Brief    : Self-checking bench for cmp_iter. Three instances
//             (32/8, 32/1, 16/16) share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cmp_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        cmpop = 1'b0;
    logic [2:0]  brop = 3'd0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;

    logic [2:0]  rdy, vld, eqo, lto, gto, tko;

    int n_tests = 0;
    int n_fail  = 0;

    int         lat_r [3];
    logic [3:0] res_r [3];

    always #5 clk = ~clk;

    cmp_iter #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
        .A(a_in), .B(b_in), .CMPOp(cmpop), .BrOp(brop),
        .out_valid(vld[0]), .out_ready(out_ready),
        .equal(eqo[0]), .less(lto[0]), .greater(gto[0]), .taken(tko[0]));

    cmp_iter #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
        .A(a_in), .B(b_in), .CMPOp(cmpop), .BrOp(brop),
        .out_valid(vld[1]), .out_ready(out_ready),
        .equal(eqo[1]), .less(lto[1]), .greater(gto[1]), .taken(tko[1]));

    cmp_iter #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]),
        .A(a_in[15:0]), .B(b_in[15:0]), .CMPOp(cmpop), .BrOp(brop),
        .out_valid(vld[2]), .out_ready(out_ready),
        .equal(eqo[2]), .less(lto[2]), .greater(gto[2]), .taken(tko[2]));

    function automatic int inst_w(input int i);
        return (i == 2) ? 16 : 32;
    endfunction

    function automatic int inst_c(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 1 : 16);
    endfunction

    // Reference result {eq, lt, gt, taken}
    function automatic logic [3:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cm, input logic [2:0] br, input int w);
        logic [31:0] ua;
        logic [31:0] ub;
        logic e, l, g, t;
        ua = (w == 16) ? {16'h0, a[15:0]} : a;
        ub = (w == 16) ? {16'h0, b[15:0]} : b;
        if (cm) l = (ua < ub);
        else if (w == 16) l = ($signed(ua[15:0]) < $signed(ub[15:0]));
        else l = ($signed(ua) < $signed(ub));
        e = (ua == ub);
        g = !e && !l;
        case (br)
            3'd0: t = e;
            3'd1: t = !e;
            3'd2: t = l;
            3'd3: t = l || e;
            3'd4: t = g;
            3'd5: t = g || e;
            default: t = 1'b0;
        endcase
        return {e, l, g, t};
    endfunction

    // Reference latency: position of first differing chunk from the MSB end
    function automatic int lat_model(input logic [31:0] a, input logic [31:0] b,
                                     input int w, input int c);
        int n;
        n = w / c;
        for (int i = n - 1; i >= 0; i--) begin
            for (int j = 0; j < c; j++) begin
                if (a[i*c+j] != b[i*c+j]) return n - i;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with all instances idle. Accepts on the next edge,
    // scrambles inputs, then records per-instance latency and result.
    task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b,
                                  input logic cm, input logic [2:0] br);
        a_in = a; b_in = b; cmpop = cm; brop = br; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a_in = ~a; b_in = $urandom; cmpop = ~cm; brop = br + 3'd1;
        for (int i = 0; i < 3; i++) lat_r[i] = 0;
        for (int k = 1; k <= 40 && vld != 3'b111; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (vld[i] && lat_r[i] == 0) lat_r[i] = k;
        end
        for (int i = 0; i < 3; i++) res_r[i] = {eqo[i], lto[i], gto[i], tko[i]};
    endtask

    task automatic verify_model(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic cm, input logic [2:0] br);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_i%0d_res", tag, i), 64'(res_r[i]), 64'(model(a, b, cm, br, inst_w(i))));
            check($sformatf("%s_i%0d_lat", tag, i), 64'(lat_r[i]),
                  64'(lat_model(a, b, inst_w(i), inst_c(i))));
        end
    endtask

    task automatic finish_op(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ready_after_hs"}, 64'(rdy), 64'(3'b111));
        check({tag, "_cleared"}, 64'({vld, eqo, lto, gto, tko}), 64'(0));
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cm;
        logic [2:0]  br;
        logic [3:0]  exp;   // {eq, lt, gt, taken} for the 32/8 instance
        int          lat;
    } vec_t;

    vec_t vecs [12];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ra, rb;
        logic        rc;
        logic [2:0]  rbr;

        vecs[0]  = '{32'h12345678, 32'h12345678, 1'b0, 3'd0, 4'b1001, 4};
        vecs[1]  = '{32'h80000000, 32'h00000000, 1'b0, 3'd2, 4'b0101, 1};
        vecs[2]  = '{32'h80000000, 32'h00000000, 1'b1, 3'd2, 4'b0010, 1};
        vecs[3]  = '{32'h00FF0010, 32'h00FF0020, 1'b1, 3'd5, 4'b0100, 4};
        vecs[4]  = '{32'h00010000, 32'h00020000, 1'b1, 3'd5, 4'b0100, 2};
        vecs[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 3'd4, 4'b0011, 4};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'd3, 4'b0101, 1};
        vecs[7]  = '{32'h00000005, 32'h00000005, 1'b1, 3'd1, 4'b1000, 4};
        vecs[8]  = '{32'h00000005, 32'h00000005, 1'b0, 3'd3, 4'b1001, 4};
        vecs[9]  = '{32'h00000005, 32'h00000005, 1'b0, 3'd6, 4'b1000, 4};
        vecs[10] = '{32'h00000100, 32'h000000FF, 1'b1, 3'd7, 4'b0010, 3};
        vecs[11] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 3'd5, 4'b0011, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(rdy), 64'(3'b111));
        check("reset_outputs", 64'({vld, eqo, lto, gto, tko}), 64'(0));
        rst_n = 1'b1;

        // Directed table; the first accept lands on the first edge after release
        for (int v = 0; v < 12; v++) begin
            start_and_wait(vecs[v].a, vecs[v].b, vecs[v].cm, vecs[v].br);
            check($sformatf("vec%0d_res", v), 64'(res_r[0]), 64'(vecs[v].exp));
            check($sformatf("vec%0d_lat", v), 64'(lat_r[0]), 64'(vecs[v].lat));
            verify_model($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].cm, vecs[v].br);
            finish_op($sformatf("vec%0d", v));
        end

        // DONE held with out_ready low: outputs stable, not ready
        start_and_wait(32'h00FF0010, 32'h00FF0020, 1'b1, 3'd3);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", k), 64'(vld), 64'(3'b111));
            check($sformatf("hold%0d_ready", k), 64'(rdy), 64'(3'b000));
            for (int i = 0; i < 3; i++)
                check($sformatf("hold%0d_i%0d_res", k, i), 64'({eqo[i], lto[i], gto[i], tko[i]}),
                      64'(model(32'h00FF0010, 32'h00FF0020, 1'b1, 3'd3, inst_w(i))));
        end
        finish_op("hold");

        // in_valid pulse during RUN/DONE ignored; no accept on the handshake edge
        a_in = 32'hCAFEBABE; b_in = 32'hCAFEBABE; cmpop = 1'b1; brop = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        a_in = 32'h0; b_in = 32'h1; brop = 3'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && vld != 3'b111; k++) begin
            @(posedge clk); #1;
        end
        check("pulse_valid", 64'(vld), 64'(3'b111));
        check("pulse_eq", 64'(eqo), 64'(3'b111));
        check("pulse_taken", 64'(tko), 64'(3'b111));
        a_in = 32'h1; b_in = 32'h2; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("hs_no_accept_ready", 64'(rdy), 64'(3'b111));
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("hs_idle%0d", k), 64'({rdy, vld}), 64'(6'b111000));
        end

        // Reset while instances are in RUN (32/8, 32/1) and DONE (16/16)
        a_in = 32'hA5A5A5A5; b_in = 32'hA5A5A5A5; cmpop = 1'b0; brop = 3'd0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_mix", 64'(vld), 64'(3'b100));
        #2 rst_n = 1'b0;
        #1;
        check("rst_run_async", 64'({vld, eqo, lto, gto, tko}), 64'(0));
        check("rst_run_ready", 64'(rdy), 64'(3'b111));
        #2 rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (vld != 3'b000 || rdy != 3'b111)
                check($sformatf("post_rst_run%0d", k), 64'({rdy, vld}), 64'(6'b111000));
        end
        check("post_rst_run_final", 64'({rdy, vld}), 64'(6'b111000));

        // Reset while all in DONE
        start_and_wait(32'h00000010, 32'h00000020, 1'b1, 3'd2);
        check("pre_rst_done", 64'(vld), 64'(3'b111));
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_async", 64'({vld, eqo, lto, gto, tko}), 64'(0));
        check("rst_done_ready", 64'(rdy), 64'(3'b111));
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", 64'({rdy, vld}), 64'(6'b111000));

        // Randomised operations against the reference model
        for (int r = 0; r < 40; r++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
                default: rb = ra ^ 32'($urandom_range(1, 255));
            endcase
            rc  = 1'($urandom_range(0, 1));
            rbr = 3'($urandom_range(0, 7));
            start_and_wait(ra, rb, rc, rbr);
            verify_model($sformatf("rnd%0d", r), ra, rb, rc, rbr);
            finish_op($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cmp_iter
`default_nettype wire
